// File: rtl/inst_fetch_unit.sv
// inst_fetch_unit: instruction-fetch front end sitting directly upstream of a combinational ROM.
//
// Owns the PC, drives the ROM chip-enable/address, captures each returned word together with its
// PC in a small FIFO, and presents the FIFO head to decode over a valid/ready handshake.
// Redirect priority: flush_i > branch_flag_i > sequential fetch.
//
// Ports:
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   stall_i             freeze PC and suppress pushes (pops still drain the queue)
//   flush_i, new_pc_i   exception redirect and handler address
//   branch_flag_i,
//   branch_target_i     taken-branch redirect and target address
//   rom_ce_o, rom_addr_o, rom_inst_i   ROM interface (rom_inst_i is combinational on rom_addr_o)
//   if_valid_o, if_pc_o, if_inst_o, id_ready_i   IF/ID handshake
//   fq_count_o          fetch-queue occupancy
module inst_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned DEPTH    = 2,
    parameter int unsigned CNT_W    = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             stall_i,
    input  logic             flush_i,
    input  logic [31:0]      new_pc_i,
    input  logic             branch_flag_i,
    input  logic [31:0]      branch_target_i,
    output logic             rom_ce_o,
    output logic [31:0]      rom_addr_o,
    input  logic [31:0]      rom_inst_i,
    output logic             if_valid_o,
    output logic [31:0]      if_pc_o,
    output logic [31:0]      if_inst_o,
    input  logic             id_ready_i,
    output logic [CNT_W-1:0] fq_count_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic             ce_q;
    logic [31:0]      pc_q, pc_d;
    logic [31:0]      last_pc_q;
    logic [31:0]      pc_mem   [DEPTH];
    logic [31:0]      inst_mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic        redirect;
    logic [31:0] redirect_pc;
    logic        pop;
    logic        push;

    assign rom_ce_o   = ce_q;
    assign rom_addr_o = pc_q & 32'hFFFF_FFFC;
    assign fq_count_o = count_q;
    assign if_valid_o = (count_q != '0);

    // Head is read straight from storage; an empty queue shows the last delivered PC.
    assign if_pc_o   = if_valid_o ? pc_mem[rd_ptr_q] : last_pc_q;
    assign if_inst_o = if_valid_o ? inst_mem[rd_ptr_q] : 32'h0;

    assign redirect    = flush_i | branch_flag_i;
    assign redirect_pc = (flush_i ? new_pc_i : branch_target_i) & 32'hFFFF_FFFC;
    assign pop         = if_valid_o & id_ready_i;
    // A full queue may still accept when the head leaves in the same cycle.
    assign push        = ce_q & ~stall_i & ~redirect & ((count_q < CNT_W'(DEPTH)) | pop);

    always_comb begin
        pc_d     = pc_q;
        count_d  = count_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (redirect) begin
            // Queue contents and the word currently on rom_inst_i are discarded.
            pc_d     = redirect_pc;
            count_d  = '0;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (push) begin
                pc_d     = rom_addr_o + 32'd4;
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            unique case ({push, pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ce_q      <= 1'b0;
            pc_q      <= RESET_PC;
            last_pc_q <= 32'h0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
        end else begin
            ce_q     <= 1'b1;
            pc_q     <= pc_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            if (if_valid_o) begin
                last_pc_q <= pc_mem[rd_ptr_q];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                pc_mem[i]   <= 32'h0;
                inst_mem[i] <= 32'h0;
            end
        end else if (push) begin
            pc_mem[wr_ptr_q]   <= rom_addr_o;
            inst_mem[wr_ptr_q] <= rom_inst_i;
        end
    end

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Directed bench for inst_fetch_unit. The ROM model returns 32'hC0DE_0000 ^ address.
module tb_inst_fetch_unit;

    logic        clk;
    logic        rst_n;
    logic        stall_i;
    logic        flush_i;
    logic [31:0] new_pc_i;
    logic        branch_flag_i;
    logic [31:0] branch_target_i;
    logic        rom_ce_o;
    logic [31:0] rom_addr_o;
    logic [31:0] rom_inst_i;
    logic        if_valid_o;
    logic [31:0] if_pc_o;
    logic [31:0] if_inst_o;
    logic        id_ready_i;
    logic [1:0]  fq_count_o;

    int checks = 0;
    int errors = 0;

    inst_fetch_unit #(
        .RESET_PC (32'h0000_0000),
        .DEPTH    (2),
        .CNT_W    (2)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .stall_i         (stall_i),
        .flush_i         (flush_i),
        .new_pc_i        (new_pc_i),
        .branch_flag_i   (branch_flag_i),
        .branch_target_i (branch_target_i),
        .rom_ce_o        (rom_ce_o),
        .rom_addr_o      (rom_addr_o),
        .rom_inst_i      (rom_inst_i),
        .if_valid_o      (if_valid_o),
        .if_pc_o         (if_pc_o),
        .if_inst_o       (if_inst_o),
        .id_ready_i      (id_ready_i),
        .fq_count_o      (fq_count_o)
    );

    assign rom_inst_i = 32'hC0DE_0000 ^ rom_addr_o;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] word(input logic [31:0] addr);
        return 32'hC0DE_0000 ^ addr;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_head(input string tag, input logic v, input logic [31:0] pc,
                            input logic [1:0] cnt);
        chk({tag, "_valid"}, {31'b0, if_valid_o}, {31'b0, v});
        chk({tag, "_count"}, {30'b0, fq_count_o}, {30'b0, cnt});
        if (v) begin
            chk({tag, "_pc"}, if_pc_o, pc);
            chk({tag, "_inst"}, if_inst_o, word(pc));
        end else begin
            chk({tag, "_inst0"}, if_inst_o, 32'h0);
        end
    endtask

    initial begin
        rst_n           = 1'b0;
        stall_i         = 1'b0;
        flush_i         = 1'b0;
        new_pc_i        = 32'h0;
        branch_flag_i   = 1'b0;
        branch_target_i = 32'h0;
        id_ready_i      = 1'b1;
        #1;
        chk("rst_ce", {31'b0, rom_ce_o}, 32'h0);
        chk("rst_addr", rom_addr_o, 32'h0);
        chk("rst_pc", if_pc_o, 32'h0);
        chk_head("rst", 1'b0, 32'h0, 2'd0);

        // Reset release and streaming fetch.
        tick();
        tick();
        rst_n = 1'b1;
        chk("rel_ce0", {31'b0, rom_ce_o}, 32'h0);
        tick();
        chk("rel_ce1", {31'b0, rom_ce_o}, 32'h1);
        chk("rel_addr", rom_addr_o, 32'h0);
        chk_head("rel", 1'b0, 32'h0, 2'd0);
        for (int k = 0; k < 4; k++) begin
            tick();
            chk_head("stream", 1'b1, 32'(4 * k), 2'd1);
            chk("stream_addr", rom_addr_o, 32'(4 * k + 4));
        end

        // Decode back-pressure: queue fills to DEPTH and PC holds.
        flush_i  = 1'b1;
        new_pc_i = 32'h0;
        tick();
        flush_i    = 1'b0;
        id_ready_i = 1'b0;
        chk_head("bp_flush", 1'b0, 32'h0, 2'd0);
        chk("bp_flush_pc_hold", if_pc_o, 32'hC);
        tick();
        chk_head("bp1", 1'b1, 32'h0, 2'd1);
        for (int k = 0; k < 4; k++) begin
            tick();
            chk_head("bp_full", 1'b1, 32'h0, 2'd2);
            chk("bp_addr", rom_addr_o, 32'h8);
        end
        id_ready_i = 1'b1;
        tick();
        chk_head("bp_rel4", 1'b1, 32'h4, 2'd2);
        tick();
        chk_head("bp_rel8", 1'b1, 32'h8, 2'd2);
        tick();
        chk_head("bp_relC", 1'b1, 32'hC, 2'd2);

        // Branch redirect with two entries queued.
        branch_flag_i   = 1'b1;
        branch_target_i = 32'h0000_0102;
        tick();
        branch_flag_i = 1'b0;
        chk_head("br", 1'b0, 32'h0, 2'd0);
        chk("br_addr", rom_addr_o, 32'h100);
        chk("br_pc_hold", if_pc_o, 32'hC);
        tick();
        chk_head("br_tgt", 1'b1, 32'h100, 2'd1);

        // Flush wins over a simultaneous branch.
        flush_i         = 1'b1;
        new_pc_i        = 32'h380;
        branch_flag_i   = 1'b1;
        branch_target_i = 32'h40;
        tick();
        flush_i       = 1'b0;
        branch_flag_i = 1'b0;
        chk("pri_addr", rom_addr_o, 32'h380);
        chk_head("pri", 1'b0, 32'h0, 2'd0);
        tick();
        chk_head("pri_tgt", 1'b1, 32'h380, 2'd1);

        // Stall drains the queue while the PC stays frozen.
        id_ready_i = 1'b0;
        tick();
        chk_head("st_fill", 1'b1, 32'h380, 2'd2);
        chk("st_fill_addr", rom_addr_o, 32'h388);
        stall_i    = 1'b1;
        id_ready_i = 1'b1;
        tick();
        chk_head("st1", 1'b1, 32'h384, 2'd1);
        chk("st1_addr", rom_addr_o, 32'h388);
        tick();
        chk_head("st2", 1'b0, 32'h0, 2'd0);
        chk("st2_addr", rom_addr_o, 32'h388);
        tick();
        chk_head("st3", 1'b0, 32'h0, 2'd0);
        chk("st3_addr", rom_addr_o, 32'h388);
        stall_i = 1'b0;
        tick();
        chk_head("st_resume", 1'b1, 32'h388, 2'd1);

        // PC wrap past the top of the address space.
        flush_i  = 1'b1;
        new_pc_i = 32'hFFFF_FFF8;
        tick();
        flush_i = 1'b0;
        chk("wr_addr", rom_addr_o, 32'hFFFF_FFF8);
        tick();
        chk_head("wr0", 1'b1, 32'hFFFF_FFF8, 2'd1);
        tick();
        chk_head("wr1", 1'b1, 32'hFFFF_FFFC, 2'd1);
        chk("wr1_addr", rom_addr_o, 32'h0);
        tick();
        chk_head("wr2", 1'b1, 32'h0000_0000, 2'd1);

        // Asynchronous reset mid-stream, checked between clock edges.
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_ce", {31'b0, rom_ce_o}, 32'h0);
        chk("arst_addr", rom_addr_o, 32'h0);
        chk("arst_pc", if_pc_o, 32'h0);
        chk_head("arst", 1'b0, 32'h0, 2'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
